gpu_fb_writer: RTL and testbench
================================

# gpu_fb_writer

Downstream stage of the GPU background renderer. Accepts 16-bit packed pixel words (8 pixels × 2-bit palette-converted shade) tagged with line and block index. Buffers them in a small FIFO, then emits them as two byte writes per word into the 160×144 2bpp frame buffer. Owns all frame buffer addressing, so the renderer no longer drives `oFramBufferAddr`/`oFramBufferWe` itself.

## Interface
Parameters:
- `FB_BASE`, 16'h0000: byte address of pixel (0,0) in the frame buffer.
- `FIFO_DEPTH`, 4: word entries; power of two, ≥2.

Ports:
- `iClock`, in, 1: single clock; all state on rising edge.
- `iReset`, in, 1: asynchronous, active-high reset.
- `iPixelWord`, in, 16: packed pixels; [15:14] leftmost pixel, [1:0] rightmost.
- `iPixelLY`, in, 8: screen line of the word.
- `iPixelBlock`, in, 5: 8-pixel column block within the line, 0..19.
- `iPixelValid`, in, 1: producer offers a word.
- `oPixelReady`, out, 1: word accepted on a cycle where `iPixelValid & oPixelReady`.
- `iClear`, in, 1: synchronous flush of FIFO and FSM.
- `oFramBufferWe`, out, 1: byte write strobe.
- `oFramBufferAddr`, out, 16: byte address.
- `oFramBufferData`, out, 8: byte data, 4 pixels, leftmost in [7:6].
- `oFrameDone`, out, 1: one-cycle pulse, last byte of line 143 block 19 written.
- `oError`, out, 1: sticky; an out-of-range word was dropped.

## Operation
- Accept condition: `iPixelValid & oPixelReady`. On accept, the word and its tag are pushed into the FIFO.
- `oPixelReady` = FIFO not full; it is combinational from the registered count.
- Range check happens at push:
  - A word with `iPixelLY ≥ 144` or `iPixelBlock ≥ 20` is accepted (handshake completes) but not stored.
  - Such a drop sets `oError`.
  - `oError` clears only on `iReset` or `iClear`.
- Address of a word: `FB_BASE + iPixelLY*40 + iPixelBlock*2`. Compute at 16 bits; the maximum offset is 5759.
  - Hi byte = word[15:8] at the word address.
  - Lo byte = word[7:0] at the word address + 1.
- FSM states:
  - IDLE: `oFramBufferWe`=0. If the FIFO is non-empty, pop and go to HI.
  - HI: outputs the hi byte with We=1; next state is LO.
  - LO: outputs the lo byte with We=1.
    - If the FIFO is non-empty, pop and go to HI (back-to-back).
    - Otherwise go to IDLE.
- A popped word's lo byte and address are held in registers until LO.
- `oFrameDone` is asserted in the cycle after the LO write of a word tagged LY=143, block=19.
- `iClear` has priority over everything else. At the next edge it:
  - empties the FIFO;
  - forces IDLE and We=0;
  - clears `oError`;
  - discards any push in the same cycle.
- Simultaneous push and pop on the same edge are both honoured; the count is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`. Count width is clog2(DEPTH)+1.

## Timing
- Reset values:
  - `oFramBufferWe`=0, `oFramBufferAddr`=0, `oFramBufferData`=0.
  - `oFrameDone`=0, `oError`=0.
  - FIFO empty, `oPixelReady`=1, FSM=IDLE.
- Frame buffer outputs are registered.
- Latency for a word accepted in cycle N:
  - Pop occurs in cycle N+1.
  - Hi byte write is visible in cycle N+2.
  - Lo byte write is visible in cycle N+3.
- Sustained throughput is one word per 2 cycles. A full FIFO deasserts `oPixelReady` in the cycle after the push that fills it.
- If reset asserts mid-transfer, the write is abandoned immediately (async) with no partial-byte completion. After release, the block resumes from IDLE.

## Structure
- Shared constants go in `gpu_definitions.v`:
  - `FB_LINE_BYTES` = 40
  - `FB_LINES` = 144
  - `FB_BLOCKS_PER_LINE` = 20
  - FSM encodings `fbw_idle`, `fbw_hi`, `fbw_lo`
- One sub-module, `sync_fifo`: parameterised width/depth, 30-bit entry (16 data + 14 precomputed address), with push/pop, count, full/empty.
- The address multiply is done at push time as (LY<<5)+(LY<<3)+(block<<1).

## Test plan
- Single word 16'hE41B, LY=0, block=0, `FB_BASE`=0 → We at N+2 with addr 0, data E4; at N+3 with addr 1, data 1B; then We=0.
- Burst of 6 words with valid held high → `oPixelReady` drops after the 4th fill. Writes appear as continuous HI/LO pairs with no IDLE gap, and the address order matches push order.
- Word LY=143, block=19 → lo-byte write to addr 5759, then `oFrameDone` pulses exactly once.
- Word LY=144, block=3 → handshake completes, no write occurs, `oError`=1 and stays 1; a subsequent `iClear` sets it to 0.
- `iClear` asserted while in HI with 3 words queued → next cycle We=0 and FIFO empty; a push offered in the clear cycle is lost.
- `iReset` pulsed mid-burst, asynchronously between edges → all outputs reach reset values immediately. After release, a new word is written at the correct address with the normal N+2 latency.

Source files
------------

// File: rtl/gpu_fb_writer_pkg.sv
// Shared definitions for the background renderer frame buffer writer.
// Holds frame buffer geometry, the writer FSM encoding and the helper
// that turns a (line, block) tag into a byte offset inside the frame.
package gpu_fb_writer_pkg;

  localparam int FB_LINE_BYTES      = 40;
  localparam int FB_LINES           = 144;
  localparam int FB_BLOCKS_PER_LINE = 20;
  localparam int FB_OFF_W           = 14;

  // Byte offset of the hi byte of the very last word of a frame
  // (line 143, block 19); its lo byte lands on the last frame byte.
  localparam logic [FB_OFF_W-1:0] FB_LAST_WORD_OFF =
    FB_OFF_W'((FB_LINES - 1) * FB_LINE_BYTES + (FB_BLOCKS_PER_LINE - 1) * 2);

  typedef enum logic [1:0] {
    fbw_idle = 2'd0,
    fbw_hi   = 2'd1,
    fbw_lo   = 2'd2
  } fbw_state_t;

  // LY*40 + block*2 built from shifts so no multiplier is inferred.
  function automatic logic [FB_OFF_W-1:0] fbWordOffset(input logic [7:0] ly,
                                                       input logic [4:0] block);
    logic [FB_OFF_W-1:0] lyExt;
    logic [FB_OFF_W-1:0] blockExt;
    lyExt    = {6'd0, ly};
    blockExt = {9'd0, block};
    return (lyExt << 5) + (lyExt << 3) + (blockExt << 1);
  endfunction

endpackage

// File: rtl/gpu_fb_writer_sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read data.
// Ports:
//   iClock, iReset     clock and async active-high reset
//   iClear             synchronous flush, wins over push/pop
//   iPush, iPushData   write side
//   iPop, oPopData     read side; oPopData is the current head entry
//   oCount, oFull, oEmpty  occupancy, derived from the registered count
module sync_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic                     iClear,
  input  logic                     iPush,
  input  logic [WIDTH-1:0]         iPushData,
  input  logic                     iPop,
  output logic [WIDTH-1:0]         oPopData,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oFull,
  output logic                     oEmpty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign oFull    = (r_count == (PTR_W+1)'(DEPTH));
  assign oEmpty   = (r_count == '0);
  assign oCount   = r_count;
  assign oPopData = r_mem[r_rdPtr];

  assign w_doPush = iPush & ~oFull & ~iClear;
  assign w_doPop  = iPop & ~oEmpty & ~iClear;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge iClock) begin
    if (w_doPush) r_mem[r_wrPtr] <= iPushData;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (iClear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_fb_writer.sv
// gpu_fb_writer: buffers tagged 16-bit pixel words (8 pixels x 2bpp) and
// writes each one into the 160x144 2bpp frame buffer as two byte writes.
// Ports:
//   iClock, iReset                    clock, async active-high reset
//   iPixelWord/LY/Block, iPixelValid  producer word, tag and offer
//   oPixelReady                       FIFO not full
//   iClear                            synchronous flush of FIFO, FSM, error
//   oFramBufferWe/Addr/Data           registered byte write port
//   oFrameDone                        pulse after the last frame byte
//   oError                            sticky out-of-range drop flag
module gpu_fb_writer
  import gpu_fb_writer_pkg::*;
#(
  parameter logic [15:0] FB_BASE    = 16'h0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iPixelWord,
  input  logic [7:0]  iPixelLY,
  input  logic [4:0]  iPixelBlock,
  input  logic        iPixelValid,
  output logic        oPixelReady,
  input  logic        iClear,
  output logic        oFramBufferWe,
  output logic [15:0] oFramBufferAddr,
  output logic [7:0]  oFramBufferData,
  output logic        oFrameDone,
  output logic        oError
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = 16 + FB_OFF_W;

  logic                 w_inRange;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic [ENTRY_W-1:0]   w_pushEntry;
  logic [ENTRY_W-1:0]   w_popEntry;
  logic [15:0]          w_popWord;
  logic [FB_OFF_W-1:0]  w_popOff;
  logic [15:0]          w_popAddr;

  fbw_state_t           r_state;
  fbw_state_t           w_nextState;
  logic                 w_startWord;
  logic                 w_nextWe;
  logic [15:0]          w_nextAddr;
  logic [7:0]           w_nextData;
  logic                 w_nextDone;

  logic [15:0]          r_loAddr;
  logic [7:0]           r_loData;
  logic                 r_loLast;

  assign w_inRange   = (iPixelLY < 8'(FB_LINES)) && (iPixelBlock < 5'(FB_BLOCKS_PER_LINE));
  assign oPixelReady = (w_count < CNT_W'(FIFO_DEPTH));
  assign w_accept    = iPixelValid & oPixelReady;
  assign w_push      = w_accept & w_inRange & ~iClear & ~w_full;
  assign w_pushEntry = {iPixelWord, fbWordOffset(iPixelLY, iPixelBlock)};

  assign w_popWord = w_popEntry[ENTRY_W-1:FB_OFF_W];
  assign w_popOff  = w_popEntry[FB_OFF_W-1:0];
  assign w_popAddr = FB_BASE + {{(16-FB_OFF_W){1'b0}}, w_popOff};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iClock    (iClock),
    .iReset    (iReset),
    .iClear    (iClear),
    .iPush     (w_push),
    .iPushData (w_pushEntry),
    .iPop      (w_pop),
    .oPopData  (w_popEntry),
    .oCount    (w_count),
    .oFull     (w_full),
    .oEmpty    (w_empty)
  );

  // FSM state register.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) r_state <= fbw_idle;
    else        r_state <= w_nextState;
  end

  // Next state and next values of the registered write port. The state
  // names describe which byte is currently on the outputs, so popping
  // a word loads its hi byte and entering LO loads the held lo byte.
  always_comb begin
    w_nextState = r_state;
    w_startWord = 1'b0;
    w_nextWe    = 1'b0;
    w_nextAddr  = oFramBufferAddr;
    w_nextData  = oFramBufferData;
    w_nextDone  = 1'b0;
    case (r_state)
      fbw_idle: begin
        if (!w_empty) w_startWord = 1'b1;
      end
      fbw_hi: begin
        w_nextState = fbw_lo;
        w_nextWe    = 1'b1;
        w_nextAddr  = r_loAddr;
        w_nextData  = r_loData;
      end
      fbw_lo: begin
        w_nextDone = r_loLast;
        if (!w_empty) w_startWord = 1'b1;
        else          w_nextState = fbw_idle;
      end
      default: w_nextState = fbw_idle;
    endcase
    if (w_startWord) begin
      w_nextState = fbw_hi;
      w_nextWe    = 1'b1;
      w_nextAddr  = w_popAddr;
      w_nextData  = w_popWord[15:8];
    end
    if (iClear) begin
      w_nextState = fbw_idle;
      w_startWord = 1'b0;
      w_nextWe    = 1'b0;
      w_nextDone  = 1'b0;
    end
  end

  assign w_pop = w_startWord;

  // Registered write port plus the lo-byte holding registers.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      oFramBufferWe   <= 1'b0;
      oFramBufferAddr <= '0;
      oFramBufferData <= '0;
      oFrameDone      <= 1'b0;
      r_loAddr        <= '0;
      r_loData        <= '0;
      r_loLast        <= 1'b0;
    end else begin
      oFramBufferWe   <= w_nextWe;
      oFramBufferAddr <= w_nextAddr;
      oFramBufferData <= w_nextData;
      oFrameDone      <= w_nextDone;
      if (w_startWord) begin
        r_loAddr <= w_popAddr + 16'd1;
        r_loData <= w_popWord[7:0];
        r_loLast <= (w_popOff == FB_LAST_WORD_OFF);
      end
    end
  end

  // Sticky drop flag; a flush clears it even if a bad word arrives alongside.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset)                        oError <= 1'b0;
    else if (iClear)                   oError <= 1'b0;
    else if (w_accept && !w_inRange)   oError <= 1'b1;
  end

endmodule

// File: tb/tb_gpu_fb_writer.sv
module tb_gpu_fb_writer;

  logic        iClock;
  logic        iReset;
  logic [15:0] iPixelWord;
  logic [7:0]  iPixelLY;
  logic [4:0]  iPixelBlock;
  logic        iPixelValid;
  logic        oPixelReady;
  logic        iClear;
  logic        oFramBufferWe;
  logic [15:0] oFramBufferAddr;
  logic [7:0]  oFramBufferData;
  logic        oFrameDone;
  logic        oError;

  int compared   = 0;
  int mismatched = 0;
  int cycleCount = 0;
  int doneCount  = 0;

  logic [15:0] wrAddrQ [$];
  logic [7:0]  wrDataQ [$];
  int          wrCycleQ [$];

  gpu_fb_writer #(
    .FB_BASE    (16'h0000),
    .FIFO_DEPTH (4)
  ) dut (
    .iClock          (iClock),
    .iReset          (iReset),
    .iPixelWord      (iPixelWord),
    .iPixelLY        (iPixelLY),
    .iPixelBlock     (iPixelBlock),
    .iPixelValid     (iPixelValid),
    .oPixelReady     (oPixelReady),
    .iClear          (iClear),
    .oFramBufferWe   (oFramBufferWe),
    .oFramBufferAddr (oFramBufferAddr),
    .oFramBufferData (oFramBufferData),
    .oFrameDone      (oFrameDone),
    .oError          (oError)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  always @(posedge iClock) cycleCount++;

  // Records every byte write seen on the write port, sampled mid-cycle.
  always @(negedge iClock) begin
    if (!iReset) begin
      if (oFramBufferWe) begin
        wrAddrQ.push_back(oFramBufferAddr);
        wrDataQ.push_back(oFramBufferData);
        wrCycleQ.push_back(cycleCount);
      end
      if (oFrameDone) doneCount++;
    end
  end

  task automatic clearLog();
    wrAddrQ.delete();
    wrDataQ.delete();
    wrCycleQ.delete();
  endtask

  task automatic test_reset();
    compared++; if (oFramBufferWe !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we: got %0b expected 0", oFramBufferWe); end
    compared++; if (oFramBufferAddr !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_addr: got %h expected 0000", oFramBufferAddr); end
    compared++; if (oFramBufferData !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_data: got %h expected 00", oFramBufferData); end
    compared++; if (oFrameDone !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %0b expected 0", oFrameDone); end
    compared++; if (oError !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_error: got %0b expected 0", oError); end
    compared++; if (oPixelReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %0b expected 1", oPixelReady); end
  endtask

  task automatic test_single_word();
    @(negedge iClock);
    clearLog();
    iPixelWord = 16'hE41B; iPixelLY = 8'd0; iPixelBlock = 5'd0; iPixelValid = 1'b1;
    compared++; if (oPixelReady !== 1'b1) begin mismatched++; $display("[TB] FAIL single_ready: got %0b expected 1", oPixelReady); end
    @(negedge iClock);
    iPixelValid = 1'b0;
    compared++; if (oFramBufferWe !== 1'b0) begin mismatched++; $display("[TB] FAIL single_n1_we: got %0b expected 0", oFramBufferWe); end
    @(negedge iClock);
    compared++; if (oFramBufferWe !== 1'b1) begin mismatched++; $display("[TB] FAIL single_n2_we: got %0b expected 1", oFramBufferWe); end
    compared++; if (oFramBufferAddr !== 16'd0) begin mismatched++; $display("[TB] FAIL single_n2_addr: got %0d expected 0", oFramBufferAddr); end
    compared++; if (oFramBufferData !== 8'hE4) begin mismatched++; $display("[TB] FAIL single_n2_data: got %h expected e4", oFramBufferData); end
    @(negedge iClock);
    compared++; if (oFramBufferWe !== 1'b1) begin mismatched++; $display("[TB] FAIL single_n3_we: got %0b expected 1", oFramBufferWe); end
    compared++; if (oFramBufferAddr !== 16'd1) begin mismatched++; $display("[TB] FAIL single_n3_addr: got %0d expected 1", oFramBufferAddr); end
    compared++; if (oFramBufferData !== 8'h1B) begin mismatched++; $display("[TB] FAIL single_n3_data: got %h expected 1b", oFramBufferData); end
    @(negedge iClock);
    compared++; if (oFramBufferWe !== 1'b0) begin mismatched++; $display("[TB] FAIL single_n4_we: got %0b expected 0", oFramBufferWe); end
    compared++; if (oFrameDone !== 1'b0) begin mismatched++; $display("[TB] FAIL single_done: got %0b expected 0", oFrameDone); end
  endtask

  // Eight words LY=2, blocks 0..7, word i = {A0+i, 50+i}; addresses run 80..95.
  task automatic test_back_to_back();
    int  guard;
    bit  seenLow;
    logic [7:0] expData;
    seenLow = 1'b0;
    @(negedge iClock);
    clearLog();
    for (int i = 0; i < 8; i++) begin
      iPixelWord  = {8'hA0 + 8'(i), 8'h50 + 8'(i)};
      iPixelLY    = 8'd2;
      iPixelBlock = 5'(i);
      iPixelValid = 1'b1;
      guard = 0;
      while (!oPixelReady && guard < 20) begin
        seenLow = 1'b1;
        @(negedge iClock);
        guard++;
      end
      if (guard >= 20) begin
        compared++; mismatched++;
        $display("[TB] FAIL burst_ready_timeout: ready stuck at %0b, expected 1 within 20 cycles", oPixelReady);
      end
      @(negedge iClock);
    end
    iPixelValid = 1'b0;
    repeat (30) @(negedge iClock);
    compared++; if (seenLow !== 1'b1) begin mismatched++; $display("[TB] FAIL burst_ready_drop: got %0b expected 1", seenLow); end
    compared++; if (wrAddrQ.size() != 16) begin mismatched++; $display("[TB] FAIL burst_count: got %0d expected 16", wrAddrQ.size()); end
    if (wrAddrQ.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        expData = (k % 2 == 0) ? (8'hA0 + 8'(k / 2)) : (8'h50 + 8'(k / 2));
        compared++; if (wrAddrQ[k] !== 16'(80 + k)) begin mismatched++; $display("[TB] FAIL burst_addr[%0d]: got %0d expected %0d", k, wrAddrQ[k], 80 + k); end
        compared++; if (wrDataQ[k] !== expData) begin mismatched++; $display("[TB] FAIL burst_data[%0d]: got %h expected %h", k, wrDataQ[k], expData); end
        compared++; if (wrCycleQ[k] != wrCycleQ[0] + k) begin mismatched++; $display("[TB] FAIL burst_gap[%0d]: got cycle %0d expected %0d", k, wrCycleQ[k], wrCycleQ[0] + k); end
      end
    end
  endtask

  task automatic test_frame_done();
    @(negedge iClock);
    clearLog();
    doneCount = 0;
    iPixelWord = 16'hC3A5; iPixelLY = 8'd143; iPixelBlock = 5'd19; iPixelValid = 1'b1;
    @(negedge iClock);
    iPixelValid = 1'b0;
    @(negedge iClock);
    compared++; if (oFramBufferAddr !== 16'd5758) begin mismatched++; $display("[TB] FAIL last_hi_addr: got %0d expected 5758", oFramBufferAddr); end
    compared++; if (oFramBufferData !== 8'hC3) begin mismatched++; $display("[TB] FAIL last_hi_data: got %h expected c3", oFramBufferData); end
    @(negedge iClock);
    compared++; if (oFramBufferWe !== 1'b1) begin mismatched++; $display("[TB] FAIL last_lo_we: got %0b expected 1", oFramBufferWe); end
    compared++; if (oFramBufferAddr !== 16'd5759) begin mismatched++; $display("[TB] FAIL last_lo_addr: got %0d expected 5759", oFramBufferAddr); end
    compared++; if (oFramBufferData !== 8'hA5) begin mismatched++; $display("[TB] FAIL last_lo_data: got %h expected a5", oFramBufferData); end
    compared++; if (oFrameDone !== 1'b0) begin mismatched++; $display("[TB] FAIL done_early: got %0b expected 0", oFrameDone); end
    @(negedge iClock);
    compared++; if (oFrameDone !== 1'b1) begin mismatched++; $display("[TB] FAIL done_pulse: got %0b expected 1", oFrameDone); end
    compared++; if (oFramBufferWe !== 1'b0) begin mismatched++; $display("[TB] FAIL done_we: got %0b expected 0", oFramBufferWe); end
    @(negedge iClock);
    compared++; if (oFrameDone !== 1'b0) begin mismatched++; $display("[TB] FAIL done_width: got %0b expected 0", oFrameDone); end
    repeat (5) @(negedge iClock);
    compared++; if (doneCount != 1) begin mismatched++; $display("[TB] FAIL done_count: got %0d expected 1", doneCount); end
  endtask

  task automatic test_range_error();
    @(negedge iClock);
    clearLog();
    iPixelWord = 16'h5A5A; iPixelLY = 8'd144; iPixelBlock = 5'd3; iPixelValid = 1'b1;
    compared++; if (oPixelReady !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_ready: got %0b expected 1", oPixelReady); end
    compared++; if (oError !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_err_before: got %0b expected 0", oError); end
    @(negedge iClock);
    iPixelValid = 1'b0;
    compared++; if (oError !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_err_set: got %0b expected 1", oError); end
    repeat (6) @(negedge iClock);
    compared++; if (wrAddrQ.size() != 0) begin mismatched++; $display("[TB] FAIL drop_no_write: got %0d writes expected 0", wrAddrQ.size()); end
    compared++; if (oError !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_err_sticky: got %0b expected 1", oError); end
    iClear = 1'b1;
    @(negedge iClock);
    iClear = 1'b0;
    compared++; if (oError !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_err_clear: got %0b expected 0", oError); end
    iPixelWord = 16'h0F0F; iPixelLY = 8'd0; iPixelBlock = 5'd20; iPixelValid = 1'b1;
    @(negedge iClock);
    iPixelValid = 1'b0;
    compared++; if (oError !== 1'b1) begin mismatched++; $display("[TB] FAIL block20_err: got %0b expected 1", oError); end
    repeat (6) @(negedge iClock);
    compared++; if (wrAddrQ.size() != 0) begin mismatched++; $display("[TB] FAIL block20_no_write: got %0d writes expected 0", wrAddrQ.size()); end
    iClear = 1'b1;
    @(negedge iClock);
    iClear = 1'b0;
  endtask

  // Six words LY=1, block k: after the sixth push the FSM shows word 2's hi byte
  // (addr 44) with words 3..5 still queued.
  task automatic test_clear();
    @(negedge iClock);
    clearLog();
    for (int k = 0; k < 6; k++) begin
      iPixelWord = {8'h10 + 8'(k), 8'h20 + 8'(k)}; iPixelLY = 8'd1; iPixelBlock = 5'(k); iPixelValid = 1'b1;
      @(negedge iClock);
    end
    compared++; if (oFramBufferWe !== 1'b1) begin mismatched++; $display("[TB] FAIL clear_pre_we: got %0b expected 1", oFramBufferWe); end
    compared++; if (oFramBufferAddr !== 16'd44) begin mismatched++; $display("[TB] FAIL clear_pre_addr: got %0d expected 44", oFramBufferAddr); end
    compared++; if (oFramBufferData !== 8'h12) begin mismatched++; $display("[TB] FAIL clear_pre_data: got %h expected 12", oFramBufferData); end
    iClear = 1'b1;
    iPixelWord = 16'h7777; iPixelLY = 8'd1; iPixelBlock = 5'd6; iPixelValid = 1'b1;
    @(negedge iClock);
    iClear = 1'b0;
    iPixelValid = 1'b0;
    compared++; if (oFramBufferWe !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_we: got %0b expected 0", oFramBufferWe); end
    compared++; if (oPixelReady !== 1'b1) begin mismatched++; $display("[TB] FAIL clear_ready: got %0b expected 1", oPixelReady); end
    clearLog();
    repeat (10) @(negedge iClock);
    compared++; if (wrAddrQ.size() != 0) begin mismatched++; $display("[TB] FAIL clear_flushed: got %0d writes expected 0", wrAddrQ.size()); end
  endtask

  task automatic test_async_reset();
    @(negedge iClock);
    for (int k = 0; k < 3; k++) begin
      iPixelWord = {8'h60 + 8'(k), 8'h70 + 8'(k)}; iPixelLY = 8'd3; iPixelBlock = 5'(k); iPixelValid = 1'b1;
      @(negedge iClock);
    end
    iPixelValid = 1'b0;
    compared++; if (oFramBufferAddr !== 16'd121) begin mismatched++; $display("[TB] FAIL arst_pre_addr: got %0d expected 121", oFramBufferAddr); end
    @(posedge iClock);
    #2;
    iReset = 1'b1;
    #1;
    compared++; if (oFramBufferWe !== 1'b0) begin mismatched++; $display("[TB] FAIL arst_we: got %0b expected 0", oFramBufferWe); end
    compared++; if (oFramBufferAddr !== 16'd0) begin mismatched++; $display("[TB] FAIL arst_addr: got %0d expected 0", oFramBufferAddr); end
    compared++; if (oFramBufferData !== 8'h00) begin mismatched++; $display("[TB] FAIL arst_data: got %h expected 00", oFramBufferData); end
    compared++; if (oPixelReady !== 1'b1) begin mismatched++; $display("[TB] FAIL arst_ready: got %0b expected 1", oPixelReady); end
    @(negedge iClock);
    iReset = 1'b0;
    clearLog();
    iPixelWord = 16'h1234; iPixelLY = 8'd5; iPixelBlock = 5'd7; iPixelValid = 1'b1;
    @(negedge iClock);
    iPixelValid = 1'b0;
    compared++; if (oFramBufferWe !== 1'b0) begin mismatched++; $display("[TB] FAIL arst_n1_we: got %0b expected 0", oFramBufferWe); end
    @(negedge iClock);
    compared++; if (oFramBufferAddr !== 16'd214) begin mismatched++; $display("[TB] FAIL arst_n2_addr: got %0d expected 214", oFramBufferAddr); end
    compared++; if (oFramBufferData !== 8'h12) begin mismatched++; $display("[TB] FAIL arst_n2_data: got %h expected 12", oFramBufferData); end
    @(negedge iClock);
    compared++; if (oFramBufferAddr !== 16'd215) begin mismatched++; $display("[TB] FAIL arst_n3_addr: got %0d expected 215", oFramBufferAddr); end
    compared++; if (oFramBufferData !== 8'h34) begin mismatched++; $display("[TB] FAIL arst_n3_data: got %h expected 34", oFramBufferData); end
    repeat (10) @(negedge iClock);
    compared++; if (wrAddrQ.size() != 2) begin mismatched++; $display("[TB] FAIL arst_writes: got %0d expected 2", wrAddrQ.size()); end
  endtask

  initial begin
    iReset      = 1'b1;
    iClear      = 1'b0;
    iPixelValid = 1'b0;
    iPixelWord  = 16'h0000;
    iPixelLY    = 8'd0;
    iPixelBlock = 5'd0;
    #2;
    test_reset();
    repeat (2) @(negedge iClock);
    iReset = 1'b0;
    test_single_word();
    test_back_to_back();
    test_frame_done();
    test_range_error();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
